// File: rtl/cwm_tx.sv
// Transmit carrier-wave modulator: pairs serial bits into I/Q symbols, holds each for
// SPS samples and mixes with a 32-entry sin/cos NCO into a 7-bit signed passband sample.
module cwm_tx #(
    parameter int SPS     = 8,
    parameter int PHASE_W = 8
) (
    input  logic                    CLK_2,
    input  logic                    RST,
    input  logic                    DIN,
    input  logic                    DIN_VALID,
    output logic                    DIN_READY,
    input  logic                    TX_EN,
    input  logic [PHASE_W-1:0]      PHASE_STEP,
    output logic signed [6:0]       TX_OUT,
    output logic                    TX_VALID,
    output logic                    SYM_STROBE
);

    localparam int CNT_W = (SPS > 2) ? $clog2(SPS) : 1;
    localparam logic [CNT_W-1:0] LAST_SAMP = CNT_W'(SPS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_reg;
    logic [PHASE_W-1:0] acc_reg;
    logic               bit_cnt_reg;
    logic               i_hold_reg;
    logic               nxt_v_reg;
    logic [1:0]         nxt_reg;      // {I, Q}
    logic [1:0]         cur_reg;      // {I, Q}
    logic [CNT_W-1:0]   samp_cnt_reg;

    // Quarter-symmetric sine table; the upper half of the cycle is the negated lower half.
    function automatic logic signed [6:0] sin_lut(input logic [4:0] k);
        logic signed [6:0] mag;
        mag = 7'sd0;
        case (k[3:0])
            4'd0:  mag = 7'sd0;
            4'd1:  mag = 7'sd6;
            4'd2:  mag = 7'sd12;
            4'd3:  mag = 7'sd17;
            4'd4:  mag = 7'sd22;
            4'd5:  mag = 7'sd26;
            4'd6:  mag = 7'sd29;
            4'd7:  mag = 7'sd30;
            4'd8:  mag = 7'sd31;
            4'd9:  mag = 7'sd30;
            4'd10: mag = 7'sd29;
            4'd11: mag = 7'sd26;
            4'd12: mag = 7'sd22;
            4'd13: mag = 7'sd17;
            4'd14: mag = 7'sd12;
            4'd15: mag = 7'sd6;
            default: mag = 7'sd0;
        endcase
        return k[4] ? -mag : mag;
    endfunction

    logic [4:0]        k_idx;
    logic signed [6:0] sin_v;
    logic signed [6:0] cos_v;
    logic signed [6:0] i_term;
    logic signed [6:0] q_term;
    logic signed [6:0] sample;

    assign k_idx = acc_reg[PHASE_W-1 -: 5];
    assign sin_v = sin_lut(k_idx);
    assign cos_v = sin_lut(k_idx + 5'd8);

    // Each term is within +-31, so the difference stays within +-62 without saturation.
    always_comb begin
        i_term = cur_reg[1] ? cos_v : -cos_v;
        q_term = cur_reg[0] ? sin_v : -sin_v;
        sample = i_term - q_term;
    end

    assign DIN_READY = !nxt_v_reg;

    always_ff @(posedge CLK_2 or negedge RST) begin
        if (!RST) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            bit_cnt_reg  <= 1'b0;
            i_hold_reg   <= 1'b0;
            nxt_v_reg    <= 1'b0;
            nxt_reg      <= 2'b00;
            cur_reg      <= 2'b00;
            samp_cnt_reg <= '0;
            TX_OUT       <= 7'sd0;
            TX_VALID     <= 1'b0;
            SYM_STROBE   <= 1'b0;
        end else begin
            // Acceptance needs nxt_v=0 and loading needs nxt_v=1, so they never collide.
            if (DIN_VALID && !nxt_v_reg) begin
                if (!bit_cnt_reg) begin
                    i_hold_reg  <= DIN;
                    bit_cnt_reg <= 1'b1;
                end else begin
                    nxt_reg     <= {i_hold_reg, DIN};
                    nxt_v_reg   <= 1'b1;
                    bit_cnt_reg <= 1'b0;
                end
            end

            case (state_reg)
                IDLE: begin
                    TX_OUT     <= 7'sd0;
                    TX_VALID   <= 1'b0;
                    SYM_STROBE <= 1'b0;
                    if (nxt_v_reg && TX_EN) begin
                        cur_reg      <= nxt_reg;
                        nxt_v_reg    <= 1'b0;
                        samp_cnt_reg <= '0;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    TX_OUT     <= sample;
                    TX_VALID   <= 1'b1;
                    SYM_STROBE <= (samp_cnt_reg == '0);
                    acc_reg    <= acc_reg + PHASE_STEP;
                    if (samp_cnt_reg != LAST_SAMP) begin
                        samp_cnt_reg <= samp_cnt_reg + 1'b1;
                    end else if (nxt_v_reg && TX_EN) begin
                        cur_reg      <= nxt_reg;
                        nxt_v_reg    <= 1'b0;
                        samp_cnt_reg <= '0;
                    end else begin
                        samp_cnt_reg <= '0;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cwm_tx.md
# cwm_tx

Transmit-side carrier-wave modulator, the counterpart of the receive-side CWM mixer. It takes a serial bit stream under a valid/ready handshake and pairs the bits into BPSK-per-rail I/Q symbols. It holds each symbol for SPS samples and mixes it with an internal sin/cos NCO, producing a 7-bit signed passband sample per CLK_2 cycle for the TX DAC path.

## Interface
- SPS, 8: samples per symbol, ≥2.
- PHASE_W, 8: phase accumulator width, ≥5; LUT index = acc[PHASE_W-1 -: 5].
- CLK_2  in  1: sample clock.
- RST  in  1: reset, asynchronous, active-low.
- DIN  in  1: serial data bit.
- DIN_VALID  in  1: DIN valid.
- DIN_READY  out  1: block can accept a bit.
- TX_EN  in  1: permits starting or continuing symbols.
- PHASE_STEP  in  PHASE_W: NCO increment per emitted sample, unsigned.
- TX_OUT  out  7 signed: modulated sample.
- TX_VALID  out  1: TX_OUT holds a live sample.
- SYM_STROBE  out  1: pulse coincident with the first sample of each symbol.

## Operation
- Bit transfer occurs when DIN_VALID && DIN_READY at a CLK_2 edge. The first bit of a pair is I and the second is Q. bit_cnt toggles 0→1→0.
- On the Q bit the pair is written into the next-symbol buffer and nxt_v is set.
- DIN_READY = !nxt_v. It does not depend on TX_EN or state.
- Mapping: bit 1 → +1, bit 0 → −1. Sample = I·COS[k] − Q·SIN[k], with k = the accumulator's top 5 bits. Range is ±62 and the result fits in 7 bits with no saturation.
- SIN LUT, 32 entries, k=0..15: 0,6,12,17,22,26,29,30,31,30,29,26,22,17,12,6. Entries k=16..31 are the negatives of entries 0..15.
- COS[k] = SIN[(k+8) mod 32].
- The phase accumulator advances by PHASE_STEP (mod 2^PHASE_W) only on cycles that emit a sample. It holds in IDLE and clears only on reset, so phase is continuous across gaps.
- FSM, two states:
  - IDLE: TX_OUT←0, TX_VALID←0, SYM_STROBE←0. If nxt_v && TX_EN: cur←next, nxt_v←0, samp_cnt←0, go to RUN.
  - RUN: TX_OUT←sample(cur, k), TX_VALID←1, SYM_STROBE←(samp_cnt==0), acc←acc+PHASE_STEP.
    - If samp_cnt<SPS-1: samp_cnt++.
    - If samp_cnt==SPS-1 and nxt_v && TX_EN: cur←next, nxt_v←0, samp_cnt←0, stay in RUN (back-to-back, no gap).
    - If samp_cnt==SPS-1 otherwise: samp_cnt←0, go to IDLE (underrun or disable).
- Dropping TX_EN mid-symbol does not truncate the symbol. The current symbol completes all SPS samples.
- A half-received pair (bit_cnt=1) persists indefinitely. It is not discarded by IDLE or TX_EN.
- Buffer load and bit acceptance cannot collide, because DIN_READY is low whenever nxt_v=1.

## Timing
- All outputs are registered.
- Reset values: TX_OUT=0, TX_VALID=0, SYM_STROBE=0, DIN_READY=1. Internally: state=IDLE, acc=0, bit_cnt=0, nxt_v=0, samp_cnt=0, cur=0.
- Latency: the Q bit is accepted at edge n. The load from IDLE happens at edge n+1. The first sample, with SYM_STROBE=1, appears after edge n+2.
- Throughput: one symbol per SPS cycles. Sustained output requires the next pair to be complete before the edge that emits sample SPS-1.
- After an underrun, TX_VALID falls at the edge following the last sample. Restart latency is then 2 cycles after nxt_v is set, or 2 cycles after TX_EN rises.
- Asynchronous RST assertion mid-symbol immediately forces the reset values. Any partial pair and any buffered symbol are lost.
- PHASE_STEP is sampled every emitting cycle and may change between samples.

## Test plan
- Reset mid-RUN: assert RST → TX_OUT=0, TX_VALID=0, DIN_READY=1 with no clock needed. After release, the first pair behaves as it would from power-up.
- PHASE_STEP=0, TX_EN=1, bits 1,0 → SPS=8 samples of +31, SYM_STROBE on the first only, then TX_VALID=0. Bits 0,1 → 8 samples of −31.
- PHASE_STEP=64 (PHASE_W=8), bits 1,1 → TX_OUT sequence 31,−31,−31,31,31,−31,−31,31. Latency is exactly 2 cycles after the Q bit.
- Continuous stream with DIN_VALID always high → DIN_READY low while the buffer is full, TX_VALID never drops, SYM_STROBE every 8 cycles, and phase continuous across symbols.
- Underrun: second pair supplied 3 cycles after the first symbol ends → exactly a 4-cycle TX_VALID=0 gap. The accumulator resumes from its held value.
- TX_EN deasserted at sample 3 → the symbol finishes all 8 samples, then IDLE. A buffered pair is held with DIN_READY=0 and is transmitted 2 cycles after TX_EN returns.
